// File: rtl/cla_sub32_serial.sv
// Multi-cycle 32-bit subtractor: d = a - b - bin, one 8-bit carry-lookahead slice per cycle.
// Define CLA_SUB32_SERIAL_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.
module cla_sub32_serial (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] d,
    output logic        bout,
    output logic        zero,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  cnt;
    logic        carry;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic        accept;
    logic        last;
    logic [4:0]  base;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  g;
    logic [7:0]  p;
    logic [7:0]  s;
    logic [8:0]  c;
    logic        prod;

    assign accept = in_valid && (state == IDLE);
    assign last   = (state == RUN) && (cnt == 2'd3);
    assign base   = {cnt, 3'b000};

    // Subtraction as a + ~b + ~bin: the carry register holds the inverted borrow.
    always_comb begin
        // NOTE: every variable driven here gets a default first so no latch is inferred.
        x    = a_q[base +: 8];
        y    = ~b_q[base +: 8];
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        prod = 1'b0;
        c[0] = carry;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i];
            prod   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (prod & g[j]);
                prod   = prod & p[j];
            end
            c[i+1] = c[i+1] | (prod & carry);
        end
        s = p ^ c[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            cnt   <= 2'd0;
            d     <= '0;
            bout  <= 1'b0;
            zero  <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            carry <= ~bin;
            cnt   <= 2'd0;
        end else if (state == RUN) begin
            d[base +: 8] <= s;
            carry        <= c[8];
            cnt          <= cnt + 2'd1;
            if (last) begin
                bout <= ~c[8];
                // Flag taken from the full word: lower slices already in d, top slice from s.
                zero <= ({s, d[23:0]} == 32'd0);
            end
        end
    end

`ifdef CLA_SUB32_SERIAL_OVF_EN
    logic ovf_q;

    // c[7] is the carry into bit 31 while the top slice is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= c[7] ^ c[8];
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/cla_sub32_serial.md
# cla_sub32_serial

Multi-cycle 32-bit subtractor computing d = a − b − bin eight bits per cycle, with one 8-bit carry-lookahead slice and a registered borrow chained between slices. Sits beside the combinational 8-bit CLA adder in the datapath library as its inverse-operation counterpart. Used where a full 32-bit subtract is needed but area matters more than latency. Valid/ready handshakes on both operand and result sides.

## Interface
- No parameters; width fixed at 32 bits, slice fixed at 8 bits, 4 slices.
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous active-high reset.
- `in_valid` input 1: operands valid.
- `in_ready` output 1: block can accept operands; high only in IDLE.
- `a` input 32: minuend.
- `b` input 32: subtrahend.
- `bin` input 1: borrow in.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `d` output 32: difference, a − b − bin mod 2^32.
- `bout` output 1: borrow out; 1 iff unsigned a < b + bin.
- `zero` output 1: 1 iff d == 0.
- `ovf` output 1: signed overflow; see Configuration.

## Operation
- States: IDLE, RUN, DONE. 2-bit slice counter `cnt`.
- IDLE: `in_ready`=1. On an edge with in_valid & in_ready: latch a, b; set carry register = ~bin; cnt=0; go to RUN. `in_valid` is ignored in every other state.
- RUN, each edge:
  - Slice sum = a[8cnt+7:8cnt] + ~b[8cnt+7:8cnt] + carry, via the 8-bit CLA slice (g = x&y, p = x^y).
  - Write the 8-bit sum to d[8cnt+7:8cnt].
  - Carry register takes the slice carry-out; cnt increments.
  - On the edge with cnt==3: bout = ~carry-out, compute zero and ovf, go to DONE.
- DONE: `out_valid`=1. d, bout, zero and ovf are held stable. On an edge with out_valid & out_ready, go to IDLE. out_valid falls and in_ready rises after that edge.
- Inputs a, b, bin are sampled only at the accept edge. Later changes have no effect.
- zero is computed from the complete 32-bit d (registered), not per slice.
- d bits from a previous result may remain visible in IDLE/RUN. They are valid only while out_valid=1.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, d=0, bout=0, zero=0, ovf=0, cnt=0, carry register=0.
- Latency: out_valid rises after the 4th rising edge following the accept edge.
- Minimum 6 edges per operation: accept, 4×RUN, output handshake. There is no overlap: a new accept cannot happen in the same edge as the output handshake.
- out_ready held low: DONE persists indefinitely, outputs frozen, in_ready=0.
- out_ready high on entering DONE: handshake completes on the first DONE edge.
- rst asserted in any state, including mid-RUN: all state and outputs go immediately to their reset values and the partial result is discarded. The first accept is possible on the first edge after rst deasserts.

## Configuration
- Macro: `CLA_SUB32_SERIAL_OVF_EN`.
- Defined:
  - Extra flop holds the carry into bit 31 during the last slice.
  - ovf = carry into bit 31 XOR carry out of bit 31, registered with bout on the cnt==3 edge.
- Undefined: ovf tied to 0; no overflow logic or flop.
- All other behaviour is identical in both builds.

## Test plan
- a=0x00000005, b=0x00000003, bin=0 → d=0x00000002, bout=0, zero=0, ovf=0; out_valid exactly 4 edges after accept.
- a=0x00000000, b=0x00000001, bin=0 → d=0xFFFFFFFF, bout=1, zero=0, ovf=0.
- a=0x80000000, b=0x00000001, bin=0 → d=0x7FFFFFFF, bout=0. With macro: ovf=1. Without macro: ovf=0.
- a=0x00000100, b=0x000000FF, bin=1 → d=0x00000000, zero=1, bout=0; exercises borrow across the slice-0/slice-1 boundary.
- Backpressure: out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands → out_valid, d and flags unchanged, in_ready=0. Then out_ready=1 → IDLE next edge, and the new operands are accepted on the following edge.
- rst pulsed while in RUN with cnt=2 → all outputs 0 and in_ready=1 immediately. After release, a=0xFFFFFFFF, b=0xFFFFFFFF, bin=0 → d=0, zero=1, bout=0.
